// File: rtl/match_sequencer.sv
// Game-flow controller for the two-team ball game: owns ball position/direction,
// scores and match state; advances the ball once per frame_tick.
module match_sequencer #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int BALL_SIZE = 8,
    parameter int PADDLE_H  = 64,
    parameter int PADDLE_W  = 8,
    parameter int PADDLE1_X = 16,
    parameter int PADDLE2_X = 616,
    parameter int SPEED     = 2,
    parameter int WIN_SCORE = 5,
    parameter int GOAL_HOLD = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [9:0] team1_ver_pos,
    input  logic [9:0] team2_ver_pos,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] state,
    output logic [1:0] winner
);

    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GOAL = 2'd2, OVER = 2'd3} state_t;

    // All geometry compares are done 11 bits wide so sums never wrap.
    localparam logic [10:0] SPD     = 11'(SPEED);
    localparam logic [10:0] BSZ     = 11'(BALL_SIZE);
    localparam logic [10:0] PH      = 11'(PADDLE_H);
    localparam logic [10:0] Y_MAX   = 11'(V_ACTIVE - BALL_SIZE);
    localparam logic [10:0] X_MAX   = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic [10:0] P1_EDGE = 11'(PADDLE1_X + PADDLE_W);
    localparam logic [10:0] P2_EDGE = 11'(PADDLE2_X);
    localparam logic [10:0] P2_STOP = 11'(PADDLE2_X - BALL_SIZE);
    localparam logic [9:0]  CX      = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0]  CY      = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [3:0]  WIN     = 4'(WIN_SCORE);
    localparam logic [7:0]  HOLD    = 8'(GOAL_HOLD);

    state_t     st, st_nx;
    logic       dir_x, dir_y;         // 1 = right / down
    logic [7:0] hold;
    logic       start_q;

    logic [9:0] x_nx, y_nx;
    logic       dx_nx, dy_nx;
    logic [3:0] s1_nx, s2_nx, s_new;
    logic [1:0] win_nx;
    logic [7:0] hold_nx;
    logic       start_rise;

    logic [10:0] x, y, p1, p2;
    logic        ovl1, ovl2;
    logic [9:0]  x_mv, y_mv;
    logic        dx_mv, dy_mv, goal1, goal2;

    assign x          = {1'b0, ball_x};
    assign y          = {1'b0, ball_y};
    assign p1         = {1'b0, team1_ver_pos};
    assign p2         = {1'b0, team2_ver_pos};
    assign ovl1       = (y + BSZ > p1) && (y < p1 + PH);
    assign ovl2       = (y + BSZ > p2) && (y < p2 + PH);
    assign start_rise = start & ~start_q;
    assign state      = st;

    // One candidate move from the current position; the FSM decides whether to take it.
    always_comb begin
        y_mv  = ball_y;
        dy_mv = dir_y;
        if (dir_y) begin
            if (y + SPD >= Y_MAX) begin
                y_mv  = 10'(Y_MAX);
                dy_mv = 1'b0;
            end else begin
                y_mv = 10'(y + SPD);
            end
        end else begin
            if (y <= SPD) begin
                y_mv  = '0;
                dy_mv = 1'b1;
            end else begin
                y_mv = 10'(y - SPD);
            end
        end

        x_mv  = ball_x;
        dx_mv = dir_x;
        goal1 = 1'b0;
        goal2 = 1'b0;
        if (!dir_x) begin
            if ((x - SPD <= P1_EDGE) && (x >= P1_EDGE) && ovl1) begin
                x_mv  = 10'(P1_EDGE);
                dx_mv = 1'b1;
            end else if (x < SPD) begin
                goal2 = 1'b1;
            end else begin
                x_mv = 10'(x - SPD);
            end
        end else begin
            if ((x + BSZ + SPD >= P2_EDGE) && (x + BSZ <= P2_EDGE) && ovl2) begin
                x_mv  = 10'(P2_STOP);
                dx_mv = 1'b0;
            end else if (x + SPD > X_MAX) begin
                goal1 = 1'b1;
            end else begin
                x_mv = 10'(x + SPD);
            end
        end
    end

    always_comb begin
        st_nx   = st;
        x_nx    = ball_x;
        y_nx    = ball_y;
        dx_nx   = dir_x;
        dy_nx   = dir_y;
        s1_nx   = score1;
        s2_nx   = score2;
        win_nx  = winner;
        hold_nx = hold;
        s_new   = goal1 ? score1 + 4'd1 : score2 + 4'd1;
        case (st)
            IDLE: begin
                if (start_rise) st_nx = PLAY;
            end
            PLAY: begin
                if (frame_tick) begin
                    if (goal1 || goal2) begin
                        // Serve toward the team that just conceded; dir_y is kept.
                        x_nx  = CX;
                        y_nx  = CY;
                        dx_nx = goal1;
                        if (goal1) s1_nx = s_new;
                        else       s2_nx = s_new;
                        if (s_new == WIN) begin
                            st_nx  = OVER;
                            win_nx = goal1 ? 2'd1 : 2'd2;
                        end else begin
                            st_nx   = GOAL;
                            hold_nx = '0;
                        end
                    end else begin
                        x_nx  = x_mv;
                        y_nx  = y_mv;
                        dx_nx = dx_mv;
                        dy_nx = dy_mv;
                    end
                end
            end
            GOAL: begin
                if (frame_tick) begin
                    hold_nx = hold + 8'd1;
                    if (hold_nx == HOLD) st_nx = PLAY;
                end
            end
            OVER: begin
                if (start_rise) begin
                    st_nx  = IDLE;
                    s1_nx  = '0;
                    s2_nx  = '0;
                    win_nx = '0;
                    dx_nx  = 1'b1;
                    dy_nx  = 1'b1;
                end
            end
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= IDLE;
            ball_x  <= CX;
            ball_y  <= CY;
            dir_x   <= 1'b1;
            dir_y   <= 1'b1;
            score1  <= '0;
            score2  <= '0;
            winner  <= '0;
            hold    <= '0;
            start_q <= 1'b0;
        end else begin
            st      <= st_nx;
            ball_x  <= x_nx;
            ball_y  <= y_nx;
            dir_x   <= dx_nx;
            dir_y   <= dy_nx;
            score1  <= s1_nx;
            score2  <= s2_nx;
            winner  <= win_nx;
            hold    <= hold_nx;
            start_q <= start;
        end
    end

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer: hand-computed ball trajectories, bounces,
// goals, goal hold, match win and asynchronous reset.
module tb_match_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic [9:0] team1_ver_pos = 10'd1000;
    logic [9:0] team2_ver_pos = 10'd1000;
    logic [9:0] ball_x, ball_y;
    logic [3:0] score1, score2;
    logic [1:0] state, winner;

    int n_checks = 0;
    int n_errors = 0;

    match_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .start         (start),
        .team1_ver_pos (team1_ver_pos),
        .team2_ver_pos (team2_ver_pos),
        .ball_x        (ball_x),
        .ball_y        (ball_y),
        .score1        (score1),
        .score2        (score2),
        .state         (state),
        .winner        (winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // All stimulus tasks start and end on a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
    endtask

    task automatic press();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        #1 rst = 1'b1;
        #1;
        check("rst_state",  state,  0);
        check("rst_x",      ball_x, 316);
        check("rst_y",      ball_y, 236);
        check("rst_s1",     score1, 0);
        check("rst_s2",     score2, 0);
        check("rst_winner", winner, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Start without a tick leaves the ball still; first tick moves diagonally.
        press();
        check("start_state", state,  1);
        check("start_x",     ball_x, 316);
        check("start_y",     ball_y, 236);
        tick(1);
        check("tick1_x", ball_x, 318);
        check("tick1_y", ball_y, 238);
        press();
        check("play_start_ignored", state, 1);

        // Start and tick in the same cycle: no motion.
        do_reset();
        start = 1'b1; frame_tick = 1'b1;
        @(negedge clk);
        start = 1'b0; frame_tick = 1'b0;
        check("same_cycle_state", state,  1);
        check("same_cycle_x",     ball_x, 316);
        check("same_cycle_y",     ball_y, 236);

        // Bottom wall bounce.
        do_reset();
        press();
        tick(118);
        check("bottom_y", ball_y, 472);
        tick(1);
        check("after_bottom_y", ball_y, 470);
        check("after_bottom_x", ball_x, 554);

        // Team2 paddle bounce, then unblocked left goal for team2.
        do_reset();
        team2_ver_pos = 10'd400;
        press();
        tick(146);
        check("p2_bounce_x", ball_x, 608);
        check("p2_bounce_y", ball_y, 416);
        tick(1);
        check("p2_after_x", ball_x, 606);
        tick(303);
        check("left_edge_x", ball_x, 0);
        tick(1);
        check("goal2_state", state,  2);
        check("goal2_s2",    score2, 1);
        check("goal2_s1",    score1, 0);
        check("goal2_x",     ball_x, 316);
        check("goal2_y",     ball_y, 236);

        // Team1 paddle bounce on the same trajectory.
        do_reset();
        team2_ver_pos = 10'd400;
        team1_ver_pos = 10'd150;
        press();
        tick(438);
        check("p1_bounce_x", ball_x, 24);
        tick(1);
        check("p1_after_x", ball_x, 26);
        team1_ver_pos = 10'd1000;

        // Right-side goal for team1, goal hold, serve toward team2.
        do_reset();
        team2_ver_pos = 10'd0;
        press();
        tick(158);
        check("right_edge_x", ball_x, 632);
        tick(1);
        check("goal1_s1",    score1, 1);
        check("goal1_state", state,  2);
        check("goal1_x",     ball_x, 316);
        check("goal1_y",     ball_y, 236);
        tick(59);
        check("hold59_state", state,  2);
        check("hold59_x",     ball_x, 316);
        tick(1);
        check("hold60_state", state,  1);
        check("hold60_x",     ball_x, 316);
        tick(1);
        check("serve_x", ball_x, 318);

        // Play on to the winning score.
        team2_ver_pos = 10'd1000;
        for (int g = 2; g <= 5; g++) begin
            cnt = 0;
            while (state == 2'd1 && cnt < 1000) begin
                tick(1);
                cnt++;
            end
            check("goal_in_time", (cnt < 1000), 1);
            check("goal_score1", score1, g);
            if (g < 5) begin
                check("goal_hold_state", state, 2);
                tick(60);
            end
        end
        check("over_state",  state,  3);
        check("over_winner", winner, 1);
        check("over_x",      ball_x, 316);
        check("over_s2",     score2, 0);
        tick(3);
        check("over_frozen_x", ball_x, 316);
        press();
        check("restart_state",  state,  0);
        check("restart_s1",     score1, 0);
        check("restart_winner", winner, 0);
        press();
        tick(1);
        check("new_match_x", ball_x, 318);
        check("new_match_y", ball_y, 238);

        // Asynchronous reset in the middle of a goal hold.
        do_reset();
        press();
        tick(159);
        check("pre_rst_state", state, 2);
        tick(30);
        #2 rst = 1'b1;
        #1;
        check("async_state", state,  0);
        check("async_x",     ball_x, 316);
        check("async_y",     ball_y, 236);
        check("async_s1",    score1, 0);
        check("async_s2",    score2, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
